neo_pixel_strand_receiver: RTL and testbench

Receive-side decoder for the NeoPixel single-wire protocol driven by the strand controller. Samples `neo_data`, classifies each high pulse as a 0 or 1 bit by width, and assembles 24-bit GRB pixel words, MSB first. Detects the latch (long-low) interval and presents a completed frame packet. It serves as the loopback checker and scoreboard source for the controller, and as the front end of a daisy-chained strand model.

---
 rtl/neo_pixel_strand_receiver.sv | 163 ++++++++++++++++
 tb/tb_neo_pixel_strand_receiver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/neo_pixel_strand_receiver.sv
// NeoPixel single-wire receiver: measures high-pulse widths into GRB pixel words
// and publishes a whole frame once the line has stayed low for the latch interval.
module neo_pixel_strand_receiver #(
    parameter int unsigned NUM_PIXELS   = 5,
    parameter int unsigned MIN_HIGH     = 4,
    parameter int unsigned ONE_THRESH   = 26,
    parameter int unsigned MAX_HIGH     = 100,
    parameter int unsigned LATCH_CYCLES = 2500
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     neo_data,
    output logic [23:0]              pixel_data,
    output logic [2:0]               pixel_index,
    output logic                     pixel_valid,
    output logic [24*NUM_PIXELS-1:0] frame_packet,
    output logic [3:0]               frame_pixels,
    output logic                     frame_done,
    output logic                     frame_error
);
    localparam int unsigned PKT_W = 24 * NUM_PIXELS;
    localparam int unsigned HI_W  = $clog2(MAX_HIGH + 2);
    localparam int unsigned LO_W  = $clog2(LATCH_CYCLES + 1);
    localparam logic [HI_W-1:0] HI_SAT   = HI_W'(MAX_HIGH + 1);
    localparam logic [LO_W-1:0] LO_LATCH = LO_W'(LATCH_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    state_t            state_q;
    logic              sync1_q, s_q, s_d_q;
    logic [HI_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [LO_W-1:0]   lo_cnt_q, lo_cnt_d;
    logic [22:0]       shift_q;
    logic [4:0]        bit_cnt_q;
    logic [3:0]        pix_cnt_q, pix_cnt_d;
    logic              err_q;
    logic [PKT_W-1:0]  buf_q, buf_d;
    logic [23:0]       word_d;
    logic [3:0]        frame_pixels_d;
    logic              rise_c, fall_c, bit_ok_c, bit_c, active_c;

    logic [23:0]       pixel_data_q;
    logic [2:0]        pixel_index_q;
    logic              pixel_valid_q;
    logic [PKT_W-1:0]  frame_packet_q;
    logic [3:0]        frame_pixels_q;
    logic              frame_done_q;
    logic              frame_error_q;

    assign rise_c = s_q & ~s_d_q;
    assign fall_c = ~s_q & s_d_q;

    // Next values for counters, the assembled word and the working buffer
    always_comb begin
        hi_cnt_d       = (hi_cnt_q == HI_SAT) ? hi_cnt_q : hi_cnt_q + HI_W'(1);
        lo_cnt_d       = (lo_cnt_q == LO_LATCH) ? lo_cnt_q : lo_cnt_q + LO_W'(1);
        pix_cnt_d      = (pix_cnt_q == 4'd15) ? pix_cnt_q : pix_cnt_q + 4'd1;
        bit_ok_c       = (hi_cnt_q >= HI_W'(MIN_HIGH)) && (hi_cnt_q <= HI_W'(MAX_HIGH));
        bit_c          = (hi_cnt_q >= HI_W'(ONE_THRESH));
        word_d         = {shift_q, bit_c};
        frame_pixels_d = (pix_cnt_q > 4'(NUM_PIXELS)) ? 4'(NUM_PIXELS) : pix_cnt_q;
        active_c       = (pix_cnt_q != 4'd0) || (bit_cnt_q != 5'd0) || err_q;
        buf_d          = buf_q;
        for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
            if (pix_cnt_q == 4'(i)) buf_d[PKT_W-1-24*i -: 24] = word_d;
        end
    end

    // Synchronizer, pulse-width FSM, pixel assembly and frame publication
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            sync1_q        <= 1'b0;
            s_q            <= 1'b0;
            s_d_q          <= 1'b0;
            hi_cnt_q       <= '0;
            lo_cnt_q       <= '0;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            pix_cnt_q      <= '0;
            err_q          <= 1'b0;
            buf_q          <= '0;
            pixel_data_q   <= '0;
            pixel_index_q  <= '0;
            pixel_valid_q  <= 1'b0;
            frame_packet_q <= '0;
            frame_pixels_q <= '0;
            frame_done_q   <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            sync1_q       <= neo_data;
            s_q           <= sync1_q;
            s_d_q         <= s_q;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise_c) begin
                        state_q  <= ST_HIGH;
                        hi_cnt_q <= HI_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (fall_c) begin
                        state_q  <= ST_LOW;
                        lo_cnt_q <= LO_W'(1);
                        if (!bit_ok_c) begin
                            err_q <= 1'b1;
                        end else begin
                            shift_q <= word_d[22:0];
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_q     <= '0;
                                pixel_data_q  <= word_d;
                                pixel_index_q <= pix_cnt_q[2:0];
                                pixel_valid_q <= 1'b1;
                                pix_cnt_q     <= pix_cnt_d;
                                if (pix_cnt_q < 4'(NUM_PIXELS)) buf_q <= buf_d;
                                else err_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end else begin
                        hi_cnt_q <= hi_cnt_d;
                    end
                end
                ST_LOW: begin
                    if (rise_c) begin
                        state_q  <= ST_HIGH;
                        hi_cnt_q <= HI_W'(1);
                    end else if (lo_cnt_d == LO_LATCH) begin
                        // A rise wins over the latch, so a gap one short of it continues the frame
                        state_q  <= ST_IDLE;
                        lo_cnt_q <= lo_cnt_d;
                        if (active_c) begin
                            frame_done_q   <= 1'b1;
                            frame_packet_q <= buf_q;
                            frame_pixels_q <= frame_pixels_d;
                            frame_error_q  <= err_q | (bit_cnt_q != 5'd0);
                        end
                        pix_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        err_q     <= 1'b0;
                        buf_q     <= '0;
                        shift_q   <= '0;
                    end else begin
                        lo_cnt_q <= lo_cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_index  = pixel_index_q;
    assign pixel_valid  = pixel_valid_q;
    assign frame_packet = frame_packet_q;
    assign frame_pixels = frame_pixels_q;
    assign frame_done   = frame_done_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_neo_pixel_strand_receiver.sv
// Directed bench for neo_pixel_strand_receiver: drives waveform-level pixel frames
// and checks decoded pixels and latched frames against hand-computed values.
module tb_neo_pixel_strand_receiver;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         neo_data = 1'b0;
    logic [23:0]  pixel_data;
    logic [2:0]   pixel_index;
    logic         pixel_valid;
    logic [119:0] frame_packet;
    logic [3:0]   frame_pixels;
    logic         frame_done;
    logic         frame_error;

    int tests_run = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [26:0] pv_q[$];

    neo_pixel_strand_receiver dut (
        .clock(clock), .reset(reset), .neo_data(neo_data),
        .pixel_data(pixel_data), .pixel_index(pixel_index), .pixel_valid(pixel_valid),
        .frame_packet(frame_packet), .frame_pixels(frame_pixels),
        .frame_done(frame_done), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    // Record every pixel and frame pulse, sampled just after the active edge
    always @(posedge clock) begin
        #1;
        if (pixel_valid) pv_q.push_back({pixel_index, pixel_data});
        if (frame_done) done_cnt++;
    end

    task automatic send_pulse(input int hi, input int lo);
        neo_data = 1'b1;
        repeat (hi) @(negedge clock);
        neo_data = 1'b0;
        repeat (lo) @(negedge clock);
    endtask

    task automatic send_bits(input logic [23:0] p, input int n, input int last_lo);
        for (int i = 23; i > 23 - n; i--) begin
            if (i == 24 - n && last_lo > 0) send_pulse(p[i] ? 35 : 18, last_lo);
            else if (p[i]) send_pulse(35, 28);
            else send_pulse(18, 45);
        end
    endtask

    task automatic latch();
        neo_data = 1'b0;
        repeat (2600) @(negedge clock);
    endtask

    task automatic clear_capture();
        pv_q.delete();
        done_cnt = 0;
    endtask

    task automatic check_frame(input string name, input logic [119:0] pkt,
                               input logic [3:0] n, input logic err);
        tests_run++;
        if (done_cnt !== 1 || frame_packet !== pkt || frame_pixels !== n || frame_error !== err) begin
            fails++;
            $display("FAIL %s: done=%0d pkt=%h n=%0d err=%b, required done=1 pkt=%h n=%0d err=%b",
                     name, done_cnt, frame_packet, frame_pixels, frame_error, pkt, n, err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({pixel_data, pixel_index, pixel_valid, frame_packet, frame_pixels, frame_done, frame_error} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: pix=%h idx=%0d pkt=%h n=%0d, required all 0",
                     pixel_data, pixel_index, frame_packet, frame_pixels);
        end
        reset = 1'b0;
        clear_capture();
        repeat (3000) @(negedge clock);
        tests_run++;
        if (done_cnt !== 0) begin
            fails++;
            $display("FAIL idle_no_frame: done pulses=%0d, required 0", done_cnt);
        end
    endtask

    task automatic test_frame_decode();
        logic [23:0] px [5];
        px[0] = 24'h005073; px[1] = 24'h000000; px[2] = 24'hB30000;
        px[3] = 24'h000000; px[4] = 24'h00FF00;
        clear_capture();
        for (int i = 0; i < 5; i++) send_bits(px[i], 24, 0);
        latch();
        tests_run++;
        if (pv_q.size() !== 5) begin
            fails++;
            $display("FAIL decode_pv_count: got %0d, required 5", pv_q.size());
        end
        for (int i = 0; i < 5 && i < pv_q.size(); i++) begin
            tests_run++;
            if (pv_q[i] !== {3'(i), px[i]}) begin
                fails++;
                $display("FAIL decode_pixel%0d: got idx/data %h, required %h", i, pv_q[i], {3'(i), px[i]});
            end
        end
        check_frame("decode_frame", 120'h005073_000000_B30000_000000_00FF00, 4'd5, 1'b0);
    endtask

    task automatic test_threshold();
        clear_capture();
        for (int i = 0; i < 24; i++) send_pulse(25, 35);
        for (int i = 0; i < 24; i++) send_pulse(26, 35);
        latch();
        tests_run++;
        if (pv_q.size() !== 2 || pv_q[0] !== {3'd0, 24'h000000} || pv_q[1] !== {3'd1, 24'hFFFFFF}) begin
            fails++;
            $display("FAIL threshold_pixels: count=%0d first=%h last=%h, required 2 / 0000000 / 1FFFFFF",
                     pv_q.size(), pv_q.size() > 0 ? pv_q[0] : 27'h0, pv_q.size() > 1 ? pv_q[1] : 27'h0);
        end
        check_frame("threshold_frame", 120'h000000_FFFFFF_000000_000000_000000, 4'd2, 1'b0);
    endtask

    task automatic test_glitch();
        clear_capture();
        send_bits(24'hA5C33C, 12, 0);
        send_pulse(2, 20);
        send_bits(24'h33C000, 12, 0);
        latch();
        tests_run++;
        if (pv_q.size() !== 1 || pv_q[0] !== {3'd0, 24'hA5C33C}) begin
            fails++;
            $display("FAIL glitch_pixel: count=%0d got=%h, required 1 / 0A5C33C",
                     pv_q.size(), pv_q.size() > 0 ? pv_q[0] : 27'h0);
        end
        check_frame("glitch_frame", {24'hA5C33C, 96'h0}, 4'd1, 1'b1);
    endtask

    task automatic test_stuck_high();
        clear_capture();
        send_bits(24'h123456, 24, 0);
        send_pulse(150, 40);
        latch();
        check_frame("stuck_high_frame", {24'h123456, 96'h0}, 4'd1, 1'b1);
    endtask

    task automatic test_partial();
        clear_capture();
        send_bits(24'hABCDEF, 24, 0);
        send_bits(24'hFC0000, 6, 0);
        latch();
        tests_run++;
        if (pixel_data !== 24'hABCDEF) begin
            fails++;
            $display("FAIL partial_pixel: got %h, required ABCDEF", pixel_data);
        end
        check_frame("partial_frame", {24'hABCDEF, 96'h0}, 4'd1, 1'b1);
    endtask

    task automatic test_overflow();
        clear_capture();
        for (int i = 1; i <= 6; i++) send_bits({6{4'(i)}}, 24, 0);
        latch();
        tests_run++;
        if (pv_q.size() !== 6 || pv_q[pv_q.size()-1] !== {3'd5, 24'h666666}) begin
            fails++;
            $display("FAIL overflow_pixels: count=%0d last=%h, required 6 / 5666666",
                     pv_q.size(), pv_q.size() > 0 ? pv_q[pv_q.size()-1] : 27'h0);
        end
        check_frame("overflow_frame", 120'h111111_222222_333333_444444_555555, 4'd5, 1'b1);
    endtask

    task automatic test_latch_boundary();
        clear_capture();
        send_bits(24'h0F0F0F, 24, 2499);
        tests_run++;
        if (done_cnt !== 0) begin
            fails++;
            $display("FAIL latch_2499_no_done: done pulses=%0d, required 0", done_cnt);
        end
        send_bits(24'hF0F0F0, 24, 0);
        latch();
        check_frame("latch_boundary_frame", {24'h0F0F0F, 24'hF0F0F0, 72'h0}, 4'd2, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        clear_capture();
        send_bits(24'hFFF000, 12, 0);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({pixel_data, pixel_index, pixel_valid, frame_packet, frame_pixels, frame_done, frame_error} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: pix=%h pkt=%h n=%0d err=%b, required all 0",
                     pixel_data, frame_packet, frame_pixels, frame_error);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        clear_capture();
        send_bits(24'h00AA55, 24, 0);
        latch();
        tests_run++;
        if (pv_q.size() !== 1 || pv_q[0] !== {3'd0, 24'h00AA55}) begin
            fails++;
            $display("FAIL mid_reset_pixel: count=%0d got=%h, required 1 / 000AA55",
                     pv_q.size(), pv_q.size() > 0 ? pv_q[0] : 27'h0);
        end
        check_frame("mid_reset_frame", {24'h00AA55, 96'h0}, 4'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame_decode();
        test_threshold();
        test_glitch();
        test_stuck_high();
        test_partial();
        test_overflow();
        test_latch_boundary();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
